pwm_compare_deadtime: RTL and testbench
=======================================

Name: pwm_compare_deadtime

Overview:
- Stage directly downstream of the free-running 10-bit PWM counter.
- Compares the counter value against a double-buffered duty register and produces complementary high-side/low-side gate outputs with programmable dead time.
- Duty updates written by software take effect only at a period boundary, so no glitching mid-period.
- Also emits a one-cycle period tick for software and other blocks.

Parameters:
- CNT_W, 10: width of counter and duty values; terminal count = 2^CNT_W-1 (1023).
- DEADTIME, 8: dead-time length in clk cycles, range 0..255; 0 disables dead-time insertion.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  PWM enable, same signal that drives the upstream counter.
- cntr  in  CNT_W  counter value from upstream; holds 1023 while en=0.
- duty_in  in  CNT_W  new duty value.
- duty_wr  in  1  one-cycle write strobe for duty_in.
- pwm_h  out  1  high-side gate drive, registered.
- pwm_l  out  1  low-side gate drive, registered.
- duty_pending  out  1  a written duty is waiting for the next period boundary.
- period_tick  out  1  one-cycle pulse marking the start of a period.

Behaviour:
- Reset (async assert, sync release): pwm_h=0, pwm_l=0, duty_pending=0, period_tick=0, duty_act=0, duty_shd=0, raw_q=0, FSM=IDLE, dead-time counter=0.
- Boundary: wrap = en & (cntr==1023).

Duty buffering:
- duty_wr & !wrap: duty_shd<=duty_in; duty_pending<=1.
- wrap & duty_pending & !duty_wr: duty_act<=duty_shd; duty_pending<=0.
- wrap & duty_wr (simultaneous): duty_act<=duty_in; duty_shd<=duty_in; duty_pending<=0.
- en=0: every cycle acts as a boundary, so a pending duty moves to duty_act at once.
- Back-to-back duty_wr before a boundary: last write wins.

Period tick:
- period_tick<=wrap, i.e. high during the cycle the counter shows 0.

Compare:
- raw_q<=en & (cntr<duty_act), unsigned compare.
- duty 0 gives constant low. duty 1023 gives high 1023 of 1024 counts.
- Because cntr is 1023 when disabled, raw_q=0 whenever en=0.

Dead-time FSM (states IDLE, LOW_ON, DEAD_LH, HIGH_ON, DEAD_HL); outputs registered, updated on the same edge as the state:
- IDLE (h=0,l=0):
  - en=1 -> DEAD_LH if raw_q=1, else -> LOW_ON.
- LOW_ON (h=0,l=1):
  - raw_q=1 -> DEAD_LH, loading dt_cnt=DEADTIME-1.
- DEAD_LH (h=0,l=0):
  - dt_cnt decrements each cycle.
  - dt_cnt==0 & raw_q=1 -> HIGH_ON.
  - raw_q=0 at any point -> LOW_ON immediately (pulse shorter than dead time is swallowed).
- HIGH_ON (h=1,l=0):
  - raw_q=0 -> DEAD_HL, loading dt_cnt=DEADTIME-1.
- DEAD_HL (h=0,l=0):
  - Mirror of DEAD_LH.
  - Ends in LOW_ON when dt_cnt==0 & raw_q=0.
  - raw_q=1 -> HIGH_ON immediately.
- en=0 in any state -> IDLE next edge; both outputs low.
- DEADTIME=0: dead states are skipped and LOW_ON<->HIGH_ON is direct.
- Invariant: pwm_h & pwm_l is never 1 in any cycle.

Latency:
- cntr sampled at edge k affects raw_q after edge k+1.
- Both gates are low after edge k+2.
- The newly active gate asserts after edge k+2+DEADTIME.

Reset mid-operation: both outputs drop low asynchronously; the pending duty is lost.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum pwm_dt_state_t {IDLE, LOW_ON, DEAD_LH, HIGH_ON, DEAD_HL};
  - localparam CNT_MAX = 2^CNT_W-1;
  - DT_W=8.
- One sub-module, pwm_deadtime_gen: takes clk, rst, en, raw_q and the DEADTIME parameter, and produces pwm_h and pwm_l.
- Duty buffering and compare stay in the top level.

Test Plan:
- Reset, en=1, duty_wr with 256 during cntr=500 -> duty_pending=1 until wrap; duty_act=256 from cntr=0; pwm_h high for 256-8 cycles per period; pwm_l high for 1024-256-8 cycles per period; two 8-cycle both-low gaps.
- duty 0 and duty 1023 -> pwm_h never high / pwm_l never high after the first dead time; period_tick every 1024 cycles.
- duty_wr coincident with cntr==1023 -> new value active at cntr=0 the same period; duty_pending stays 0.
- duty=4, DEADTIME=8 -> raw pulse swallowed: pwm_h stays 0, pwm_l drops for 4 cycles only, never both high.
- Drop en mid-HIGH_ON, then assert rst mid-DEAD_LH -> both outputs 0 next edge / immediately; all registers at reset values.
- Random duty writes over 50 periods -> assertion pwm_h&pwm_l==0 every cycle; every dead gap is at least DEADTIME cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM compare/dead-time stage
package pwm_pkg;
   localparam int PWM_CNT_W = 10;
   localparam int CNT_MAX   = (1 << PWM_CNT_W) - 1;
   localparam int DT_W      = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOW_ON,
      DEAD_LH,
      HIGH_ON,
      DEAD_HL
   } pwm_dt_state_t;
endpackage

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - complementary gate drive with dead-time insertion
// from the registered raw compare result.
module pwm_deadtime_gen
   import pwm_pkg::*;
#(
   parameter int DEADTIME = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic raw_q,
   output logic pwm_h,
   output logic pwm_l
);
   localparam bit HAS_DT = (DEADTIME != 0);
   localparam logic [DT_W-1:0] DT_LOAD = (DEADTIME > 0) ? DT_W'(DEADTIME - 1) : '0;

   pwm_dt_state_t   state_q, state_d;
   logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
   logic            pwm_h_q, pwm_h_d;
   logic            pwm_l_q, pwm_l_d;

   always_comb begin
      state_d  = state_q;
      dt_cnt_d = dt_cnt_q;
      if (!en) begin
         state_d  = IDLE;
         dt_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE, LOW_ON: begin
               if (raw_q) begin
                  if (HAS_DT) begin
                     state_d  = DEAD_LH;
                     dt_cnt_d = DT_LOAD;
                  end else begin
                     state_d = HIGH_ON;
                  end
               end else begin
                  state_d = LOW_ON;
               end
            end
            DEAD_LH: begin
               // a raw pulse shorter than the dead time never reaches the high side
               if (!raw_q)               state_d  = LOW_ON;
               else if (dt_cnt_q == '0)  state_d  = HIGH_ON;
               else                      dt_cnt_d = dt_cnt_q - 1'b1;
            end
            HIGH_ON: begin
               if (!raw_q) begin
                  if (HAS_DT) begin
                     state_d  = DEAD_HL;
                     dt_cnt_d = DT_LOAD;
                  end else begin
                     state_d = LOW_ON;
                  end
               end
            end
            DEAD_HL: begin
               if (raw_q)                state_d  = HIGH_ON;
               else if (dt_cnt_q == '0)  state_d  = LOW_ON;
               else                      dt_cnt_d = dt_cnt_q - 1'b1;
            end
            default: begin
               state_d  = IDLE;
               dt_cnt_d = '0;
            end
         endcase
      end
      pwm_h_d = (state_d == HIGH_ON);
      pwm_l_d = (state_d == LOW_ON);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         dt_cnt_q <= '0;
         pwm_h_q  <= 1'b0;
         pwm_l_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dt_cnt_q <= dt_cnt_d;
         pwm_h_q  <= pwm_h_d;
         pwm_l_q  <= pwm_l_d;
      end
   end

   assign pwm_h = pwm_h_q;
   assign pwm_l = pwm_l_q;
endmodule

// File: rtl/pwm_compare_deadtime.sv
// rtl/pwm_compare_deadtime.sv - double-buffered duty compare against the PWM
// counter, period tick, and dead-time gate generation.
module pwm_compare_deadtime
   import pwm_pkg::*;
#(
   parameter int CNT_W    = PWM_CNT_W,
   parameter int DEADTIME = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cntr,
   input  logic [CNT_W-1:0] duty_in,
   input  logic             duty_wr,
   output logic             pwm_h,
   output logic             pwm_l,
   output logic             duty_pending,
   output logic             period_tick
);
   localparam logic [CNT_W-1:0] TERM = {CNT_W{1'b1}};

   logic             at_term, wrap, boundary;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0] duty_shd_q, duty_shd_d;
   logic             duty_pending_q, duty_pending_d;
   logic             period_tick_q, period_tick_d;
   logic             raw_q, raw_d;

   assign at_term  = (cntr == TERM);
   assign wrap     = en & at_term;
   // while disabled every cycle is a boundary so software writes land at once
   assign boundary = ~en | at_term;

   always_comb begin
      duty_act_d     = duty_act_q;
      duty_shd_d     = duty_shd_q;
      duty_pending_d = duty_pending_q;
      if (duty_wr && boundary) begin
         duty_act_d     = duty_in;
         duty_shd_d     = duty_in;
         duty_pending_d = 1'b0;
      end else if (duty_wr) begin
         duty_shd_d     = duty_in;
         duty_pending_d = 1'b1;
      end else if (boundary && duty_pending_q) begin
         duty_act_d     = duty_shd_q;
         duty_pending_d = 1'b0;
      end
      period_tick_d = wrap;
      raw_d         = en & (cntr < duty_act_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_act_q     <= '0;
         duty_shd_q     <= '0;
         duty_pending_q <= 1'b0;
         period_tick_q  <= 1'b0;
         raw_q          <= 1'b0;
      end else begin
         duty_act_q     <= duty_act_d;
         duty_shd_q     <= duty_shd_d;
         duty_pending_q <= duty_pending_d;
         period_tick_q  <= period_tick_d;
         raw_q          <= raw_d;
      end
   end

   pwm_deadtime_gen #(
      .DEADTIME(DEADTIME)
   ) u_deadtime (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .raw_q(raw_q),
      .pwm_h(pwm_h),
      .pwm_l(pwm_l)
   );

   assign duty_pending = duty_pending_q;
   assign period_tick  = period_tick_q;
endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// tb/tb_pwm_compare_deadtime.sv - randomized and directed bench for pwm_compare_deadtime
module tb_pwm_compare_deadtime;
   import pwm_pkg::*;

   localparam int DT = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [9:0] cntr;
   logic [9:0] duty_in;
   logic       duty_wr;
   logic       pwm_h, pwm_l, duty_pending, period_tick;

   always #5 clk = ~clk;

   pwm_compare_deadtime #(
      .CNT_W   (10),
      .DEADTIME(DT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cntr        (cntr),
      .duty_in     (duty_in),
      .duty_wr     (duty_wr),
      .pwm_h       (pwm_h),
      .pwm_l       (pwm_l),
      .duty_pending(duty_pending),
      .period_tick (period_tick)
   );

   int checks = 0;
   int failures = 0;

   // reference: duty buffers plus, for the gates, the side last committed to
   // and how many consecutive edges the raw compare has held its value
   int m_shd, m_act, side, run_len, cnt_now;
   bit m_pend, m_raw, m_tick, m_h, m_l, r_last;

   int n_h, n_l, n_both, n_tick, gap, last_on;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_shd = 0; m_act = 0; m_pend = 0; m_raw = 0; m_tick = 0;
      m_h = 0; m_l = 0; side = 0; run_len = 0; r_last = 0;
   endtask

   task automatic model_step();
      bit bnd, raw_new;
      if (rst) begin
         model_reset();
         return;
      end
      bnd     = !en || (int'(cntr) == CNT_MAX);
      raw_new = en && (int'(cntr) < m_act);
      if (m_raw == r_last) run_len++;
      else begin
         r_last  = m_raw;
         run_len = 1;
      end
      if (!en) begin
         side = 0; m_h = 0; m_l = 0;
      end else if (m_raw) begin
         if (side == 2 || run_len >= DT + 1) side = 2;
         m_h = (side == 2); m_l = 0;
      end else begin
         if (side != 2 || run_len >= DT + 1) side = 1;
         m_l = (side == 1); m_h = 0;
      end
      if (duty_wr && bnd) begin
         m_act = int'(duty_in); m_shd = int'(duty_in); m_pend = 0;
      end else if (duty_wr) begin
         m_shd = int'(duty_in); m_pend = 1;
      end else if (bnd && m_pend) begin
         m_act = m_shd; m_pend = 0;
      end
      m_raw  = raw_new;
      m_tick = en && (int'(cntr) == CNT_MAX);
   endtask

   task automatic run_cycle(input bit wr, input logic [9:0] din);
      int cur;
      cntr    = en ? 10'(cnt_now) : 10'(CNT_MAX);
      duty_wr = wr;
      duty_in = din;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_val("outs", 32'({pwm_h, pwm_l, duty_pending, period_tick}),
                32'({m_h, m_l, m_pend, m_tick}));
      check_val("overlap", 32'(pwm_h & pwm_l), 32'd0);
      n_h    += int'(pwm_h);
      n_l    += int'(pwm_l);
      n_both += int'(!pwm_h && !pwm_l);
      n_tick += int'(period_tick);
      if (!en || rst) begin
         last_on = 0; gap = 0;
      end else if (pwm_h || pwm_l) begin
         cur = pwm_h ? 2 : 1;
         if (last_on != 0 && cur != last_on) check_val("dead_gap", 32'(gap >= DT), 32'd1);
         last_on = cur; gap = 0;
      end else begin
         gap++;
      end
      cnt_now = en ? (cnt_now + 1) % (CNT_MAX + 1) : CNT_MAX;
      duty_wr = 1'b0;
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 1100 && cnt_now != target; i++) run_cycle(1'b0, '0);
   endtask

   task automatic measure();
      n_h = 0; n_l = 0; n_both = 0; n_tick = 0;
      repeat (CNT_MAX + 1) run_cycle(1'b0, '0);
   endtask

   task automatic load_duty(input logic [9:0] v);
      run_cycle(1'b1, v);
      run_to(0);
      repeat (CNT_MAX + 1) run_cycle(1'b0, '0);
   endtask

   task automatic check_period(input string tag, input int eh, input int el, input int eb);
      measure();
      check_val({tag, "_h"}, 32'(n_h), 32'(eh));
      check_val({tag, "_l"}, 32'(n_l), 32'(el));
      check_val({tag, "_both"}, 32'(n_both), 32'(eb));
      check_val({tag, "_tick"}, 32'(n_tick), 32'd1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; duty_wr = 1'b0; duty_in = '0; cntr = 10'(CNT_MAX);
      cnt_now = CNT_MAX; gap = 0; last_on = 0;
      model_reset();
      #1;
      check_val("reset", 32'({pwm_h, pwm_l, duty_pending, period_tick}), 32'd0);
      @(negedge clk);
      run_cycle(1'b0, '0);
      run_cycle(1'b0, '0);
      rst = 1'b0;

      // duty 256 written mid-period, takes effect at the wrap
      en = 1'b1;
      run_to(500);
      run_cycle(1'b1, 10'd256);
      check_val("pend_set", 32'(duty_pending), 32'd1);
      run_to(0);
      check_val("pend_clr", 32'(duty_pending), 32'd0);
      repeat (CNT_MAX + 1) run_cycle(1'b0, '0);
      check_period("d256", 256 - DT, 1024 - 256 - DT, 2 * DT);

      load_duty(10'd0);
      check_period("d0", 0, 1024, 0);
      load_duty(10'd1023);
      check_period("d1023", 1023, 0, 1);

      load_duty(10'd256);
      run_to(CNT_MAX);
      run_cycle(1'b1, 10'd512);
      check_val("coin_pend", 32'(duty_pending), 32'd0);
      check_period("coin512", 512 - DT, 512 - DT, 2 * DT);

      load_duty(10'd4);
      check_period("d4", 0, 1020, 4);

      // enable drop in HIGH_ON, then async reset in DEAD_LH with a pending write
      load_duty(10'd512);
      run_to(200);
      check_val("pre_drop", 32'({pwm_h, pwm_l}), 32'b10);
      en = 1'b0;
      run_cycle(1'b0, '0);
      check_val("en_drop", 32'({pwm_h, pwm_l}), 32'd0);
      en = 1'b1;
      run_cycle(1'b0, '0);
      run_cycle(1'b1, 10'd77);
      check_val("pend_mid", 32'(duty_pending), 32'd1);
      repeat (3) run_cycle(1'b0, '0);
      check_val("pre_rst", 32'({pwm_h, pwm_l}), 32'd0);
      #2 rst = 1'b1;
      #1;
      check_val("rst_async", 32'({pwm_h, pwm_l, duty_pending, period_tick}), 32'd0);
      run_cycle(1'b0, '0);
      run_cycle(1'b0, '0);
      rst = 1'b0;
      check_period("post_rst", 0, 1024, 0);

      // random writes, small duties and occasional enable drops
      for (int p = 0; p < 50 * 1024; p++) begin
         if (en && $urandom_range(0, 4999) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         if ($urandom_range(0, 299) == 0)
            run_cycle(1'b1, ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12))
                                                        : 10'($urandom_range(0, 1023)));
         else
            run_cycle(1'b0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
